// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the CPU's 40-bit program memory.
// Receives a framed byte stream (COUNT byte N, N*5 big-endian data bytes,
// XOR checksum byte), writes each assembled word into program memory and
// keeps the CPU held until the image is complete and the checksum matches.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_byte, i_valid      incoming stream byte and its valid flag
//   o_ready              loader accepts a byte this cycle
//   i_restart            pulse: leave DONE/ERROR and return to IDLE
//   o_we/o_waddr/o_wdata program memory write port (1-cycle strobe)
//   o_cpu_hold           high while the CPU must not run
//   o_done, o_err        good image loaded / checksum mismatch or timeout
module prog_loader #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_WIDTH       = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_restart,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [39:0]           o_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int unsigned CNT_WIDTH = 9;
    // N=0 selects the largest image a single COUNT byte can describe.
    localparam int unsigned MAX_WORDS = (ADDR_WIDTH >= 8) ? 256 : (1 << ADDR_WIDTH);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  n_words;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic [2:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           asm_q;     // first four bytes of the current word
    logic [7:0]            csum;
    logic [TO_WIDTH-1:0]   to_cnt;

    logic accept_c;
    assign accept_c = i_valid && o_ready;

    // Frame sequencer, assembly, write port and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            addr       <= '0;
            asm_q      <= '0;
            csum       <= '0;
            to_cnt     <= '0;
            o_ready    <= 1'b1;
            o_we       <= 1'b0;
            o_waddr    <= '0;
            o_wdata    <= '0;
            o_cpu_hold <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_cpu_hold <= 1'b1;
                    if (accept_c) begin
                        n_words  <= (i_byte == 8'd0) ? CNT_WIDTH'(MAX_WORDS)
                                                     : CNT_WIDTH'(i_byte);
                        word_cnt <= '0;
                        byte_idx <= '0;
                        addr     <= '0;
                        csum     <= '0;
                        to_cnt   <= '0;
                        state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (accept_c) begin
                        to_cnt <= '0;
                        asm_q  <= {asm_q[23:0], i_byte};
                        csum   <= csum ^ i_byte;
                        if (byte_idx == 3'd4) begin
                            byte_idx <= '0;
                            o_we     <= 1'b1;
                            o_waddr  <= addr;
                            o_wdata  <= {asm_q, i_byte};
                            // Wraps to 0 after the last word of a full image.
                            addr     <= addr + 1'b1;
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt + 1'b1 == n_words) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= S_ERROR;
                        o_err   <= 1'b1;
                        o_ready <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (accept_c) begin
                        to_cnt  <= '0;
                        o_ready <= 1'b0;
                        if (i_byte == csum) begin
                            state      <= S_DONE;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            o_err <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= S_ERROR;
                        o_err   <= 1'b1;
                        o_ready <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_DONE, S_ERROR: begin
                    if (i_restart) begin
                        state      <= S_IDLE;
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
                        csum       <= '0;
                        to_cnt     <= '0;
                        o_cpu_hold <= 1'b1;
                        o_ready    <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, bad checksum, timeout,
// mid-frame reset, full 256-word image at full rate, and bytes sent in DONE.
module tb_prog_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [7:0]    i_byte = 8'd0;
    logic          i_valid = 1'b0;
    logic          i_restart = 1'b0;
    logic          o_ready;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [39:0]   o_wdata;
    logic          o_cpu_hold;
    logic          o_done;
    logic          o_err;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] log_addr[$];
    logic [39:0]   log_data[$];

    prog_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .TO_WIDTH      (5)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_byte    (i_byte),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_restart (i_restart),
        .o_we      (o_we),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_cpu_hold(o_cpu_hold),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Record every write strobe mid-cycle.
    always @(negedge i_clk) begin
        if (o_we) begin
            log_addr.push_back(o_waddr);
            log_data.push_back(o_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte for exactly one rising edge; returns 1 time unit after it.
    task automatic send(input logic [7:0] b);
        i_byte  = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic restart_pulse();
        i_restart = 1'b1;
        @(posedge i_clk);
        #1;
        i_restart = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_frame2(input logic [7:0] chk);
        logic [7:0] fr [12];
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h80, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00};
        fr[11] = chk;
        for (int i = 0; i < 11; i++) send(fr[i]);
        check("hold_before_chk", o_cpu_hold, 1);
        check("done_before_chk", o_done, 0);
        send(fr[11]);
    endtask

    function automatic logic [39:0] word_of(input int w);
        logic [7:0] b;
        b = 8'(w);
        return {b, b ^ 8'hA5, 8'h3C, ~b, b + 8'd1};
    endfunction

    initial begin
        logic [39:0] wd;
        logic [7:0]  csum;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_we", o_we, 0);
        check("rst_waddr", o_waddr, 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_hold", o_cpu_hold, 1);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Good N=2 frame
        clear_log();
        send_frame2(8'hC0);
        check("a_done", o_done, 1);
        check("a_hold", o_cpu_hold, 0);
        check("a_ready", o_ready, 0);
        check("a_err", o_err, 0);
        check("a_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("a_addr0", log_addr[0], 0);
            check("a_data0", log_data[0], 40'h0000000001);
            check("a_addr1", log_addr[1], 1);
            check("a_data1", log_data[1], 40'h8000000041);
        end
        restart_pulse();
        check("a_rs_done", o_done, 0);
        check("a_rs_hold", o_cpu_hold, 1);
        check("a_rs_ready", o_ready, 1);

        // Bad checksum
        clear_log();
        send_frame2(8'hC1);
        check("b_err", o_err, 1);
        check("b_done", o_done, 0);
        check("b_hold", o_cpu_hold, 1);
        check("b_ready", o_ready, 0);
        check("b_nwr", log_addr.size(), 2);
        restart_pulse();
        check("b_rs_err", o_err, 0);
        check("b_rs_ready", o_ready, 1);

        // Timeout after three data bytes
        clear_log();
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        repeat (TO - 1) @(posedge i_clk);
        #1;
        check("to_err_early", o_err, 0);
        check("to_ready_early", o_ready, 1);
        @(posedge i_clk);
        #1;
        check("to_err", o_err, 1);
        check("to_done", o_done, 0);
        check("to_hold", o_cpu_hold, 1);
        check("to_nwr", log_addr.size(), 0);
        restart_pulse();

        // Reset mid-frame, then a fresh N=1 frame
        clear_log();
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("mr_ready", o_ready, 1);
        check("mr_hold", o_cpu_hold, 1);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        send(8'h11);
        check("mr_done", o_done, 1);
        check("mr_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("mr_addr", log_addr[0], 0);
            check("mr_data", log_data[0], 40'h1122334455);
        end

        // Bytes offered while DONE are not consumed
        clear_log();
        i_byte  = 8'h03;
        i_valid = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("dn_ready", o_ready, 0);
        check("dn_done", o_done, 1);
        check("dn_hold", o_cpu_hold, 0);
        check("dn_nwr", log_addr.size(), 0);
        restart_pulse();

        // N=0: 256 words back-to-back with valid held high
        clear_log();
        csum    = 8'h00;
        i_byte  = 8'h00;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        for (int w = 0; w < 256; w++) begin
            wd = word_of(w);
            for (int b = 0; b < 5; b++) begin
                i_byte = wd[39 - 8*b -: 8];
                csum   = csum ^ i_byte;
                @(posedge i_clk);
                #1;
            end
        end
        i_byte = csum;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("full_done", o_done, 1);
        check("full_err", o_err, 0);
        check("full_nwr", log_addr.size(), 256);
        if (log_addr.size() == 256) begin
            for (int w = 0; w < 256; w++) begin
                check("full_addr", log_addr[w], 64'(w));
                check("full_data", log_data[w], word_of(w));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time loader that sits directly upstream of the CPU's 40-bit program memory.
- Accepts a framed byte stream over a valid/ready byte interface (from a UART receiver) and assembles 5-byte big-endian instruction words.
- Writes each word into program memory through a write port and holds the CPU stalled until the image is complete and verified.
- Reports completion or error; the CPU is released only on a good image.

Parameters:
- ADDR_WIDTH, 8, program memory address width; max image = 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes once a frame has started.
- TO_WIDTH, 20, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_byte  in  8  stream data byte
- i_valid  in  1  i_byte valid
- o_ready  out  1  loader can accept a byte
- i_restart  in  1  single-cycle pulse; leaves DONE/ERROR and returns to IDLE
- o_we  out  1  program memory write strobe, 1-cycle pulse
- o_waddr  out  ADDR_WIDTH  program memory write address
- o_wdata  out  40  program memory write data
- o_cpu_hold  out  1  high = CPU must not advance (PC held at 0)
- o_done  out  1  image loaded and checksum good
- o_err  out  1  checksum mismatch or timeout

Behaviour:
- Reset values: state=IDLE, o_ready=1, o_we=0, o_waddr=0, o_wdata=0, o_cpu_hold=1, o_done=0, o_err=0, counters=0, checksum=0.
- Byte transfer occurs on a rising edge when i_valid && o_ready. o_ready=1 in IDLE, COUNT, DATA and CHECK; 0 in DONE and ERROR.
- Frame format: COUNT byte N, then N*5 data bytes, then a CHK byte.
  - N=0 means 2**ADDR_WIDTH words; for ADDR_WIDTH>8, N is a single byte, so max = 256 words.
  - Within each word, the MSB byte comes first: byte0 -> wdata[39:32], ..., byte4 -> wdata[7:0].
- IDLE: o_cpu_hold=1. The first accepted byte is taken as N; the word counter, byte index and address are cleared. Go to DATA. No timeout in IDLE.
- DATA: each accepted byte shifts into the assembly register and is XORed into the running checksum. The COUNT byte is excluded from the checksum.
  - On the 5th byte of a word: o_we pulses high the next cycle with o_waddr=word index and o_wdata=assembled word. The address increments after the write.
  - o_ready stays 1; the write never stalls the stream. Back-to-back bytes at full rate are legal.
  - After word N is written, go to CHECK. The last write and the CHECK entry happen in the same cycle.
- CHECK: the next accepted byte is compared with the running XOR. Equal: DONE; o_done=1, o_cpu_hold=0 the following cycle. Not equal: ERROR; o_err=1, o_cpu_hold=1.
- Timeout: in DATA and CHECK, a counter increments each cycle without an accepted byte and clears on an accepted byte.
  - At TIMEOUT_CYCLES it goes to ERROR. Words already written stay in memory; o_done stays 0.
- DONE/ERROR: outputs hold. i_restart returns to IDLE next cycle, clearing o_done, o_err and the checksum, and setting o_cpu_hold=1. In other states, i_restart is ignored.
- i_valid with o_ready=0: the byte is not consumed and there is no side effect.
- Asynchronous reset mid-frame: immediate return to reset values. A pending o_we is dropped. The next byte is treated as a COUNT byte.
- Address wrap: with N=0 at ADDR_WIDTH=8, addresses 0..255 are written and the address counter wraps to 0 harmlessly after the final write.

Test Plan:
- Load N=2: bytes 02, 00 00 00 00 01, 80 00 00 00 41, CHK=C0 -> writes (0, 0x0000000001) and (1, 0x8000000041); o_done=1 and o_cpu_hold=0 one cycle after CHK.
- Same frame with CHK=C1 -> both writes occur; o_err=1, o_done=0, o_cpu_hold=1, o_ready=0. Then i_restart pulse -> IDLE; o_err=0, o_ready=1.
- N=1, three data bytes, then idle with TIMEOUT_CYCLES=16 -> ERROR exactly 16 cycles after the last byte; no o_we.
- Assert i_rst for 1 cycle after the 3rd data byte of word 0, then send a full N=1 frame -> exactly one write at address 0 with the new data; o_done=1.
- N=0 (256 words) at full rate with i_valid held high -> 256 o_we pulses at addresses 0..255 in order; checksum accepted; o_done=1.
- Send bytes while in DONE -> o_ready=0; no writes; state and outputs unchanged.
